// File: rtl/nv_nvdla_cacc_group_ctrl.sv
// rtl/nv_nvdla_cacc_group_ctrl.sv - ping-pong register group launch/completion controller for CACC
//
// Sequences layers across two software register groups. Hardware owns group
// "consumer": when that group's op_en is set, the controller launches the layer,
// waits for the datapath done pulse, clears the op_en, raises the done interrupt,
// and then hands ownership to the other group.
//
// Ports:
//   nvdla_core_clk     in   core clock
//   nvdla_core_rstn    in   asynchronous active-low reset
//   producer           in   group software is currently programming
//   reg2dp_d0_op_en    in   group 0 launch request (level)
//   reg2dp_d1_op_en    in   group 1 launch request (level)
//   dp2reg_done        in   layer-complete pulse from the datapath
//   consumer           out  group owned by hardware
//   status_0/status_1  out  per-group state: 0 idle, 1 running, 2 pending
//   op_load            out  one-cycle pulse, start layer with group "consumer"
//   d0/d1_op_en_clr    out  one-cycle pulse clearing that group's op_en
//   intr_done          out  one-cycle pulse per group at layer completion
//   wr_conflict        out  sticky: software re-armed the group that is running
//   done_err           out  sticky: done pulse arrived outside BUSY
module nv_nvdla_cacc_group_ctrl (
   input  logic       nvdla_core_clk,
   input  logic       nvdla_core_rstn,
   input  logic       producer,
   input  logic       reg2dp_d0_op_en,
   input  logic       reg2dp_d1_op_en,
   input  logic       dp2reg_done,
   output logic       consumer,
   output logic [1:0] status_0,
   output logic [1:0] status_1,
   output logic       op_load,
   output logic       d0_op_en_clr,
   output logic       d1_op_en_clr,
   output logic [1:0] intr_done,
   output logic       wr_conflict,
   output logic       done_err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      BUSY   = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic       d0_op_en_q;
   logic       d1_op_en_q;
   logic       cons_op_en;
   logic       cons_op_en_q;
   logic       hw_active;
   logic [1:0] status_0_nxt;
   logic [1:0] status_1_nxt;
   logic       conflict_set;
   logic       done_err_set;

   // op_en of the hardware-owned group, now and one cycle ago (for edge detect)
   assign cons_op_en   = consumer ? reg2dp_d1_op_en : reg2dp_d0_op_en;
   assign cons_op_en_q = consumer ? d1_op_en_q      : d0_op_en_q;

   always_comb begin
      state_nxt    = state;
      op_load      = 1'b0;
      d0_op_en_clr = 1'b0;
      d1_op_en_clr = 1'b0;
      hw_active    = 1'b0;
      conflict_set = 1'b0;
      done_err_set = 1'b0;
      case (state)
         IDLE: begin
            if (cons_op_en) begin
               state_nxt = LAUNCH;
            end
            done_err_set = dp2reg_done;
         end
         LAUNCH: begin
            op_load      = 1'b1;
            hw_active    = 1'b1;
            state_nxt    = BUSY;
            done_err_set = dp2reg_done;
            conflict_set = (producer == consumer) && cons_op_en && !cons_op_en_q;
         end
         BUSY: begin
            // op_en dropping here does not abort; only the done pulse ends the layer
            hw_active    = 1'b1;
            conflict_set = (producer == consumer) && cons_op_en && !cons_op_en_q;
            if (dp2reg_done) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            hw_active    = 1'b1;
            d0_op_en_clr = !consumer;
            d1_op_en_clr = consumer;
            done_err_set = dp2reg_done;
            state_nxt    = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      status_0_nxt = (hw_active && !consumer) ? 2'd1 : (reg2dp_d0_op_en ? 2'd2 : 2'd0);
      status_1_nxt = (hw_active &&  consumer) ? 2'd1 : (reg2dp_d1_op_en ? 2'd2 : 2'd0);
   end

   assign intr_done = {d1_op_en_clr, d0_op_en_clr};

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         state       <= IDLE;
         consumer    <= 1'b0;
         status_0    <= 2'd0;
         status_1    <= 2'd0;
         d0_op_en_q  <= 1'b0;
         d1_op_en_q  <= 1'b0;
         wr_conflict <= 1'b0;
         done_err    <= 1'b0;
      end else begin
         state      <= state_nxt;
         status_0   <= status_0_nxt;
         status_1   <= status_1_nxt;
         d0_op_en_q <= reg2dp_d0_op_en;
         d1_op_en_q <= reg2dp_d1_op_en;
         // ownership flips as DONE exits so the next IDLE looks at the other group
         if (state == DONE) begin
            consumer <= !consumer;
         end
         if (conflict_set) begin
            wr_conflict <= 1'b1;
         end
         if (done_err_set) begin
            done_err <= 1'b1;
         end
      end
   end

endmodule
